conv_layer_sequencer: RTL and testbench

Parametrised top-level sequencer for the convolution accelerator. It walks an output-map × input-map tiling loop over runtime-configured layer dimensions and issues one phase at a time to the datapath engines: IFM load, weight load, OFM load, convolution and write-back. It skips redundant IFM and OFM loads and reports partial edge tiles. It sits between the host command channel and the buffer/compute engines.

---
 rtl/conv_layer_sequencer_if.sv | 33 +++
 rtl/conv_layer_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Handshake and status bundle between the convolution layer sequencer and
// its host / datapath engines. The master modport is the sequencer side;
// the slave modport is the host command channel plus the engines.
interface conv_layer_sequencer_if #(
  parameter int unsigned IDX_W = 10
);
  logic [7:0]       host_cmd;
  logic [IDX_W-1:0] cfg_m;
  logic [IDX_W-1:0] cfg_n;
  logic             phase_done;
  logic [2:0]       phase;
  logic             phase_start;
  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] n_idx;
  logic [IDX_W-1:0] tile_m;
  logic [IDX_W-1:0] tile_n;
  logic             ofm_clear;
  logic             busy;
  logic             done;
  logic [7:0]       msg;

  modport master (
    input  host_cmd, cfg_m, cfg_n, phase_done,
    output phase, phase_start, m_idx, n_idx, tile_m, tile_n,
           ofm_clear, busy, done, msg
  );

  modport slave (
    output host_cmd, cfg_m, cfg_n, phase_done,
    input  phase, phase_start, m_idx, n_idx, tile_m, tile_n,
           ofm_clear, busy, done, msg
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks the output-map x input-map tiling loop
// and issues one engine phase at a time (IFM load, weight load, OFM load,
// convolution, write-back). IFM loads are skipped when m_idx != 0 and OFM
// loads are skipped when n_idx == 0.
// Optional feature macro: SEQ_STEP_EN adds a host single-step STEP state
// after every completed phase.
module conv_layer_sequencer #(
  parameter int unsigned TM        = 4,
  parameter int unsigned TN        = 4,
  parameter int unsigned IDX_W     = 10,
  parameter logic [7:0]  CMD_START = 8'h01,
  parameter logic [7:0]  CMD_ABORT = 8'hFF
) (
  input logic                    clk,
  input logic                    reset_n,
  conv_layer_sequencer_if.master bus
);

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_IFM  = 3'd1;
  localparam logic [2:0] PH_W    = 3'd2;
  localparam logic [2:0] PH_OFM  = 3'd3;
  localparam logic [2:0] PH_CONV = 3'd4;
  localparam logic [2:0] PH_WB   = 3'd5;

  localparam logic [IDX_W:0] TM_W = (IDX_W+1)'(TM);
  localparam logic [IDX_W:0] TN_W = (IDX_W+1)'(TN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
`ifdef SEQ_STEP_EN
    S_STEP,
`endif
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q;
  logic [2:0]       phase_q, phase_d;
  logic [IDX_W-1:0] m_total_q, m_total_d;
  logic [IDX_W-1:0] n_total_q, n_total_d;
  logic [IDX_W-1:0] m_idx_q, m_idx_d;
  logic [IDX_W-1:0] n_idx_q, n_idx_d;
  logic [IDX_W-1:0] tile_m_q, tile_m_d;
  logic [IDX_W-1:0] tile_n_q, tile_n_d;
  logic             ofm_clear_q, ofm_clear_d;
  logic             done_q, done_d;
  logic             fin_q, fin_d;

  logic [2:0]       after_phase;
  logic [IDX_W:0]   m_step;
  logic [IDX_W:0]   n_step;
  logic [7:0]       msg;

  // Live map count of a tile: min(tile size, total - base), kept one bit wider.
  function automatic logic [IDX_W-1:0] clip(input logic [IDX_W:0] total,
                                            input logic [IDX_W:0] base,
                                            input logic [IDX_W:0] tsize);
    logic [IDX_W:0] rem;
    rem = total - base;
    return (rem > tsize) ? tsize[IDX_W-1:0] : rem[IDX_W-1:0];
  endfunction

  // Registers: command sample, FSM state, tile indices and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q       <= 8'h00;
      state_q     <= S_IDLE;
      phase_q     <= PH_IDLE;
      m_total_q   <= '0;
      n_total_q   <= '0;
      m_idx_q     <= '0;
      n_idx_q     <= '0;
      tile_m_q    <= '0;
      tile_n_q    <= '0;
      ofm_clear_q <= 1'b0;
      done_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      cmd_q       <= bus.host_cmd;
      state_q     <= state_d;
      phase_q     <= phase_d;
      m_total_q   <= m_total_d;
      n_total_q   <= n_total_d;
      m_idx_q     <= m_idx_d;
      n_idx_q     <= n_idx_d;
      tile_m_q    <= tile_m_d;
      tile_n_q    <= tile_n_d;
      ofm_clear_q <= ofm_clear_d;
      done_q      <= done_d;
      fin_q       <= fin_d;
    end
  end

  // Phase that follows the current one within a tile; PH_IDLE after write-back.
  always_comb begin
    after_phase = PH_IDLE;
    case (phase_q)
      PH_IFM:  after_phase = PH_W;
      PH_W:    after_phase = (n_idx_q != '0) ? PH_OFM : PH_CONV;
      PH_OFM:  after_phase = PH_CONV;
      PH_CONV: after_phase = PH_WB;
      default: after_phase = PH_IDLE;
    endcase
  end

  // Next-state logic: tiling loop, phase issue, abort override, output pulses.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    m_total_d = m_total_q;
    n_total_d = n_total_q;
    m_idx_d   = m_idx_q;
    n_idx_d   = n_idx_q;
    tile_m_d  = tile_m_q;
    tile_n_d  = tile_n_q;
    fin_d     = fin_q;
    m_step    = {1'b0, m_idx_q} + TM_W;
    n_step    = {1'b0, n_idx_q} + TN_W;

    case (state_q)
      S_IDLE: begin
        if (cmd_q == CMD_START) begin
          m_total_d = bus.cfg_m;
          n_total_d = bus.cfg_n;
          m_idx_d   = '0;
          n_idx_d   = '0;
          tile_m_d  = clip({1'b0, bus.cfg_m}, '0, TM_W);
          tile_n_d  = clip({1'b0, bus.cfg_n}, '0, TN_W);
          if (bus.cfg_m == '0 || bus.cfg_n == '0) begin
            state_d = S_FINISH;
            fin_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            phase_d = PH_IFM;
            fin_d   = 1'b0;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.phase_done) begin
`ifdef SEQ_STEP_EN
          state_d = S_STEP;
`else
          if (after_phase == PH_IDLE) begin
            state_d = S_ADVANCE;
            phase_d = PH_IDLE;
          end else begin
            state_d = S_ISSUE;
            phase_d = after_phase;
          end
`endif
        end
      end
`ifdef SEQ_STEP_EN
      S_STEP: begin
        if (cmd_q == {5'b00010, phase_q}) begin
          if (after_phase == PH_IDLE) begin
            state_d = S_ADVANCE;
            phase_d = PH_IDLE;
          end else begin
            state_d = S_ISSUE;
            phase_d = after_phase;
          end
        end
      end
`endif
      S_ADVANCE: begin
        if (m_step < {1'b0, m_total_q}) begin
          m_idx_d  = m_step[IDX_W-1:0];
          tile_m_d = clip({1'b0, m_total_q}, m_step, TM_W);
          state_d  = S_ISSUE;
          phase_d  = PH_W;
        end else if (n_step < {1'b0, n_total_q}) begin
          n_idx_d  = n_step[IDX_W-1:0];
          m_idx_d  = '0;
          tile_m_d = clip({1'b0, m_total_q}, '0, TM_W);
          tile_n_d = clip({1'b0, n_total_q}, n_step, TN_W);
          state_d  = S_ISSUE;
          phase_d  = PH_IFM;
        end else begin
          state_d = S_FINISH;
          fin_d   = 1'b1;
        end
      end
      S_FINISH: begin
        if (cmd_q != CMD_START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_q == CMD_ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      phase_d = PH_IDLE;
      fin_d   = 1'b0;
    end

    ofm_clear_d = (phase_d == PH_CONV) && (n_idx_d == '0);
    done_d      = (state_d == S_FINISH) && (state_q != S_FINISH);
  end

  // Host status byte derived from the current state and phase.
  always_comb begin
    msg = 8'h00;
    case (state_q)
      S_IDLE:   msg = fin_q ? 8'hD0 : 8'h00;
      S_FINISH: msg = 8'hD0;
`ifdef SEQ_STEP_EN
      S_STEP:   msg = {5'b00010, phase_q};
`endif
      default:  msg = {5'b10000, phase_q};
    endcase
  end

  assign bus.phase       = phase_q;
  assign bus.phase_start = (state_q == S_ISSUE);
  assign bus.m_idx       = m_idx_q;
  assign bus.n_idx       = n_idx_q;
  assign bus.tile_m      = tile_m_q;
  assign bus.tile_n      = tile_n_q;
  assign bus.ofm_clear   = ofm_clear_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign bus.done        = done_q;
  assign bus.msg         = msg;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed testbench for conv_layer_sequencer (TM=TN=4, IDX_W=10).
// Build with SEQ_STEP_EN defined to exercise the single-step mode instead
// of the normal tiling scenarios.
module tb_conv_layer_sequencer;
  localparam int unsigned IDX_W     = 10;
  localparam logic [7:0]  CMD_START = 8'h01;
  localparam logic [7:0]  CMD_ABORT = 8'hFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  conv_layer_sequencer_if #(.IDX_W(IDX_W)) bus ();

  conv_layer_sequencer #(
    .TM(4), .TN(4), .IDX_W(IDX_W), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  int ph_log[$], clr_log[$], m_log[$], n_log[$], tm_log[$], tn_log[$], msg_log[$];
  int e_ph[$], e_clr[$], e_m[$], e_n[$], e_tm[$], e_tn[$];
  int done_cnt, done_iter, abort_iter, ab_phase, ab_busy, ab_msg, ab_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int m, input int n);
    bus.cfg_m = IDX_W'(m);
    bus.cfg_n = IDX_W'(n);
  endtask

  // Issues START, acts as the engine (phase_done one cycle after each
  // phase_start) and logs every issued phase. Iteration k = k-th sample
  // after START was driven.
  task automatic run_layer(input int max_it, input bit hold, input bit stop_on_done,
                           input int abort_ph);
    int pend;
    pend = 0;
    ph_log.delete(); clr_log.delete(); m_log.delete(); n_log.delete();
    tm_log.delete(); tn_log.delete(); msg_log.delete();
    done_cnt = 0; done_iter = -1; abort_iter = -1; ab_done = 0;
    bus.host_cmd = CMD_START;
    for (int c = 0; c < max_it; c++) begin
      tick();
      if (c == 0 && !hold) bus.host_cmd = 8'h00;
      bus.phase_done = (pend != 0);
      pend = 0;
      if (bus.phase_start) begin
        ph_log.push_back(int'(bus.phase));
        clr_log.push_back(int'(bus.ofm_clear));
        m_log.push_back(int'(bus.m_idx));
        n_log.push_back(int'(bus.n_idx));
        tm_log.push_back(int'(bus.tile_m));
        tn_log.push_back(int'(bus.tile_n));
        msg_log.push_back(int'(bus.msg));
        pend = 1;
        if (abort_ph != 0 && int'(bus.phase) == abort_ph && abort_iter < 0) begin
          bus.host_cmd = CMD_ABORT;
          abort_iter = c;
        end
      end
      if (abort_iter >= 0 && c == abort_iter + 2) begin
        ab_phase = int'(bus.phase);
        ab_busy  = int'(bus.busy);
        ab_msg   = int'(bus.msg);
        ab_done  = int'(bus.done);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_iter < 0) done_iter = c + 1;
        if (stop_on_done) break;
      end
    end
    bus.phase_done = 1'b0;
  endtask

  task automatic compare_logs(input string tag);
    checkOutput({tag, " phase count"}, ph_log.size(), e_ph.size());
    for (int i = 0; i < e_ph.size(); i++) begin
      if (i < ph_log.size()) begin
        checkOutput($sformatf("%s phase[%0d]", tag, i), ph_log[i], e_ph[i]);
        checkOutput($sformatf("%s ofm_clear[%0d]", tag, i), clr_log[i], e_clr[i]);
        checkOutput($sformatf("%s m_idx[%0d]", tag, i), m_log[i], e_m[i]);
        checkOutput($sformatf("%s n_idx[%0d]", tag, i), n_log[i], e_n[i]);
        checkOutput($sformatf("%s tile_m[%0d]", tag, i), tm_log[i], e_tm[i]);
        checkOutput($sformatf("%s tile_n[%0d]", tag, i), tn_log[i], e_tn[i]);
        checkOutput($sformatf("%s msg[%0d]", tag, i), msg_log[i], 32'h80 | e_ph[i]);
      end
    end
  endtask

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired passed=%0d total=%0d", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    bus.host_cmd = 8'h00;
    bus.phase_done = 1'b0;
    applyStimulus(0, 0);
    reset_n = 1'b0;
    repeat (3) tick();

    checkOutput("rst phase", bus.phase, 0);
    checkOutput("rst phase_start", bus.phase_start, 0);
    checkOutput("rst m_idx", bus.m_idx, 0);
    checkOutput("rst n_idx", bus.n_idx, 0);
    checkOutput("rst tile_m", bus.tile_m, 0);
    checkOutput("rst tile_n", bus.tile_n, 0);
    checkOutput("rst ofm_clear", bus.ofm_clear, 0);
    checkOutput("rst busy", bus.busy, 0);
    checkOutput("rst done", bus.done, 0);
    checkOutput("rst msg", bus.msg, 8'h00);

    reset_n = 1'b1;
    repeat (2) tick();

`ifdef SEQ_STEP_EN
    applyStimulus(4, 4);
    bus.host_cmd = CMD_START;
    tick();
    bus.host_cmd = 8'h00;
    tick();
    checkOutput("step ifm start", bus.phase_start, 1);
    checkOutput("step ifm phase", bus.phase, 1);
    tick();
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    checkOutput("step msg ifm", bus.msg, 8'h11);
    bus.host_cmd = 8'h11;
    tick();
    tick();
    checkOutput("step w start", bus.phase_start, 1);
    checkOutput("step w phase", bus.phase, 2);
    bus.host_cmd = 8'h00;
    tick();
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    checkOutput("step msg w", bus.msg, 8'h12);
    bus.host_cmd = 8'h13;
    repeat (3) tick();
    checkOutput("step wrong code msg", bus.msg, 8'h12);
    checkOutput("step wrong code no start", bus.phase_start, 0);
    bus.host_cmd = 8'h12;
    tick();
    checkOutput("step release latency", bus.phase_start, 0);
    tick();
    checkOutput("step conv start", bus.phase_start, 1);
    checkOutput("step conv phase", bus.phase, 4);
    bus.host_cmd = CMD_ABORT;
    repeat (2) tick();
    checkOutput("step abort busy", bus.busy, 0);
    checkOutput("step abort phase", bus.phase, 0);
`else
    // M=8, N=8: four tiles with IFM/OFM skipping.
    applyStimulus(8, 8);
    run_layer(100, 1'b0, 1'b1, 0);
    e_ph  = '{1,2,4,5, 2,4,5, 1,2,3,4,5, 2,3,4,5};
    e_clr = '{0,0,1,0, 0,1,0, 0,0,0,0,0, 0,0,0,0};
    e_m   = '{0,0,0,0, 4,4,4, 0,0,0,0,0, 4,4,4,4};
    e_n   = '{0,0,0,0, 0,0,0, 4,4,4,4,4, 4,4,4,4};
    e_tm  = '{4,4,4,4, 4,4,4, 4,4,4,4,4, 4,4,4,4};
    e_tn  = '{4,4,4,4, 4,4,4, 4,4,4,4,4, 4,4,4,4};
    compare_logs("m8n8");
    checkOutput("m8n8 done count", done_cnt, 1);
    checkOutput("m8n8 done iter", done_iter, 38);
    checkOutput("m8n8 finish msg", bus.msg, 8'hD0);
    checkOutput("m8n8 finish busy", bus.busy, 0);
    repeat (3) tick();
    checkOutput("m8n8 idle msg held", bus.msg, 8'hD0);
    checkOutput("m8n8 done one pulse", bus.done, 0);

    // M=6, N=3: partial edge tiles.
    applyStimulus(6, 3);
    run_layer(100, 1'b0, 1'b1, 0);
    e_ph  = '{1,2,4,5, 2,4,5};
    e_clr = '{0,0,1,0, 0,1,0};
    e_m   = '{0,0,0,0, 4,4,4};
    e_n   = '{0,0,0,0, 0,0,0};
    e_tm  = '{4,4,4,4, 2,2,2};
    e_tn  = '{3,3,3,3, 3,3,3};
    compare_logs("m6n3");
    checkOutput("m6n3 done count", done_cnt, 1);
    checkOutput("m6n3 done iter", done_iter, 18);
    repeat (3) tick();

    // cfg_m = 0: immediate finish, no phases.
    applyStimulus(0, 5);
    run_layer(10, 1'b0, 1'b1, 0);
    checkOutput("m0 phase count", ph_log.size(), 0);
    checkOutput("m0 done iter", done_iter, 2);
    checkOutput("m0 msg", bus.msg, 8'hD0);
    repeat (3) tick();

    // START held through completion, then restart after release.
    applyStimulus(4, 4);
    run_layer(30, 1'b1, 1'b0, 0);
    checkOutput("hold done count", done_cnt, 1);
    checkOutput("hold phase count", ph_log.size(), 4);
    checkOutput("hold done iter", done_iter, 11);
    bus.host_cmd = 8'h00;
    repeat (3) tick();
    checkOutput("hold release busy", bus.busy, 0);
    checkOutput("hold release msg", bus.msg, 8'hD0);
    run_layer(40, 1'b0, 1'b1, 0);
    checkOutput("rerun done count", done_cnt, 1);
    checkOutput("rerun phase count", ph_log.size(), 4);
    checkOutput("rerun first phase", (ph_log.size() > 0) ? ph_log[0] : -1, 1);
    checkOutput("rerun done iter", done_iter, 11);
    repeat (3) tick();

    // ABORT during CONV, coincident with phase_done.
    applyStimulus(8, 8);
    run_layer(20, 1'b0, 1'b0, 4);
    checkOutput("abort iter", abort_iter, 5);
    checkOutput("abort phase", ab_phase, 0);
    checkOutput("abort busy", ab_busy, 0);
    checkOutput("abort msg", ab_msg, 8'h00);
    checkOutput("abort done pulse", ab_done, 0);
    checkOutput("abort done count", done_cnt, 0);
    checkOutput("abort phase count", ph_log.size(), 3);
    bus.host_cmd = 8'h00;
    repeat (2) tick();
    applyStimulus(4, 4);
    run_layer(40, 1'b0, 1'b1, 0);
    checkOutput("post-abort first phase", (ph_log.size() > 0) ? ph_log[0] : -1, 1);
    checkOutput("post-abort m_idx", (m_log.size() > 0) ? m_log[0] : -1, 0);
    checkOutput("post-abort n_idx", (n_log.size() > 0) ? n_log[0] : -1, 0);
    checkOutput("post-abort phase count", ph_log.size(), 4);
    checkOutput("post-abort done iter", done_iter, 11);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
